board_scanner: RTL and testbench

- Upstream raster stage of the 2048 video path.
- Generates VGA 640x480@60 timing from the system clock and tracks which board tile the beam is over.
- Drives the per-pixel glyph renderer with the tile value, the glyph window origin (x_offset, y_offset), the beam position (x, y) and a glyph-window-valid flag (active_pixel).
- Holds a frame-stable snapshot of the 4x4 board so that tile values never change mid-frame (no tearing).

---
 rtl/game_2048_pkg.sv | 21 ++
 rtl/vga_timing.sv | 63 ++++++
 rtl/board_scanner.sv | 135 +++++++++++++
 tb/tb_board_scanner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_2048_pkg.sv
// Shared VGA 640x480@60 timing constants and board types for the 2048 video path.
package game_2048_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int BOARD_N  = 4;
   localparam int TILE_W   = 12;

   typedef logic [TILE_W-1:0] tile_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider and VGA raster counters with registered sync pulses.
module vga_timing
   import game_2048_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [9:0] x_nxt,
   output logic [9:0] y_nxt,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div;
   logic             x_last;
   logic             y_last;

   assign tick   = (div == DIV_W'(CLK_DIV - 1));
   assign x_last = (x == 10'(H_TOTAL - 1));
   assign y_last = (y == 10'(V_TOTAL - 1));

   always_comb begin
      x_nxt = x_last ? '0 : x + 10'd1;
      y_nxt = y;
      if (x_last) begin
         y_nxt = y_last ? '0 : y + 10'd1;
      end
   end

   // Held low during reset so no output claims a visible pixel before the raster starts.
   assign video_on = ~rst & (x < 10'(H_ACTIVE)) & (y < 10'(V_ACTIVE));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div         <= '0;
         x           <= '0;
         y           <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         div         <= tick ? '0 : div + 1'b1;
         frame_start <= tick && (x_nxt == '0) && (y_nxt == '0);
         if (tick) begin
            x     <= x_nxt;
            y     <= y_nxt;
            hsync <= !((x_nxt >= 10'(H_ACTIVE + H_FP)) &&
                       (x_nxt <  10'(H_ACTIVE + H_FP + H_SYNC)));
            vsync <= !((y_nxt >= 10'(V_ACTIVE + V_FP)) &&
                       (y_nxt <  10'(V_ACTIVE + V_FP + V_SYNC)));
         end
      end
   end

endmodule

// File: rtl/board_scanner.sv
// Raster front end of the 2048 renderer: tracks the tile under the beam with counters
// and serves tile values from a snapshot taken once per frame at the start of vblank.
module board_scanner
   import game_2048_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int BOARD_X0 = 100,
   parameter int BOARD_Y0 = 20,
   parameter int CELL     = 110,
   parameter int MARGIN   = 5,
   parameter int GLYPH    = 100
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [BOARD_N*BOARD_N*TILE_W-1:0] board,
   output logic                           hsync,
   output logic                           vsync,
   output logic                           video_on,
   output logic [9:0]                     x,
   output logic [9:0]                     y,
   output logic                           in_board,
   output logic [TILE_W-1:0]              number,
   output logic [9:0]                     x_offset,
   output logic [9:0]                     y_offset,
   output logic                           active_pixel,
   output logic                           frame_start
);

   localparam int CW = $clog2(CELL);

   logic          tick;
   logic [9:0]    x_nxt;
   logic [9:0]    y_nxt;
   logic          line_wrap;

   logic [2:0]    col, row;
   logic [CW-1:0] cell_x, cell_y;
   logic [9:0]    tile_x0, tile_y0;
   logic          run_x, run_y;
   tile_t         snap [BOARD_N*BOARD_N];

   logic          glyph_x, glyph_y;

   vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .x           (x),
      .y           (y),
      .x_nxt       (x_nxt),
      .y_nxt       (y_nxt),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .frame_start (frame_start)
   );

   assign line_wrap = tick && (x_nxt == '0);

   // Column tracking; col saturates at BOARD_N so a long right margin never aliases back in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col     <= '0;
         cell_x  <= '0;
         tile_x0 <= '0;
         run_x   <= 1'b0;
      end else if (tick) begin
         if (x_nxt == 10'(BOARD_X0)) begin
            col     <= '0;
            cell_x  <= '0;
            tile_x0 <= 10'(BOARD_X0);
            run_x   <= 1'b1;
         end else if (x_nxt == '0) begin
            run_x   <= 1'b0;
         end else if (run_x) begin
            if (cell_x == CW'(CELL - 1)) begin
               cell_x <= '0;
               if (col != 3'(BOARD_N)) begin
                  col     <= col + 3'd1;
                  tile_x0 <= tile_x0 + 10'(CELL);
               end
            end else begin
               cell_x <= cell_x + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row     <= '0;
         cell_y  <= '0;
         tile_y0 <= '0;
         run_y   <= 1'b0;
      end else if (line_wrap) begin
         if (y_nxt == 10'(BOARD_Y0)) begin
            row     <= '0;
            cell_y  <= '0;
            tile_y0 <= 10'(BOARD_Y0);
            run_y   <= 1'b1;
         end else if (y_nxt == '0) begin
            run_y   <= 1'b0;
         end else if (run_y) begin
            if (cell_y == CW'(CELL - 1)) begin
               cell_y <= '0;
               if (row != 3'(BOARD_N)) begin
                  row     <= row + 3'd1;
                  tile_y0 <= tile_y0 + 10'(CELL);
               end
            end else begin
               cell_y <= cell_y + 1'b1;
            end
         end
      end
   end

   // Copy at the first blanked line so tile values are frozen for the whole visible frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BOARD_N*BOARD_N; i++) snap[i] <= '0;
      end else if (line_wrap && (y_nxt == 10'(V_ACTIVE))) begin
         for (int i = 0; i < BOARD_N*BOARD_N; i++) snap[i] <= board[TILE_W*i +: TILE_W];
      end
   end

   assign in_board = run_x & run_y & (col < 3'(BOARD_N)) & (row < 3'(BOARD_N));
   assign glyph_x  = (cell_x >= CW'(MARGIN)) && (cell_x <= CW'(MARGIN + GLYPH - 1));
   assign glyph_y  = (cell_y >= CW'(MARGIN)) && (cell_y <= CW'(MARGIN + GLYPH - 1));

   assign number       = in_board ? snap[{row[1:0], col[1:0]}] : '0;
   assign x_offset     = in_board ? tile_x0 + 10'(MARGIN) : '0;
   assign y_offset     = in_board ? tile_y0 + 10'(MARGIN) : '0;
   assign active_pixel = video_on & in_board & glyph_x & glyph_y;

endmodule

// File: tb/tb_board_scanner.sv
// Scoreboard bench for board_scanner: expected pixels are queued in raster order and
// checked by a monitor when the beam reaches them; sync and frame timing are measured directly.
module tb_board_scanner;
   import game_2048_pkg::*;

   localparam int DIV = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [191:0] board;
   logic         hsync, vsync, video_on, in_board, active_pixel, frame_start;
   logic [9:0]   x, y, x_offset, y_offset;
   logic [11:0]  number;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string name;
      int    px;
      int    py;
      int    ib;
      int    num;
      int    xo;
      int    yo;
      int    act;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;

   board_scanner #(.CLK_DIV(DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .board        (board),
      .hsync        (hsync),
      .vsync        (vsync),
      .video_on     (video_on),
      .x            (x),
      .y            (y),
      .in_board     (in_board),
      .number       (number),
      .x_offset     (x_offset),
      .y_offset     (y_offset),
      .active_pixel (active_pixel),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   task automatic push(input string nm, input int px, input int py, input int ib,
                       input int num, input int xo, input int yo, input int act);
      exp_t e;
      e.name = nm; e.px = px; e.py = py; e.ib = ib;
      e.num = num; e.xo = xo; e.yo = yo; e.act = act;
      exp_q.push_back(e);
   endtask

   task automatic set_tile(input int idx, input int val);
      board[12*idx +: 12] = 12'(val);
   endtask

   task automatic wait_xy(input int wx, input int wy, input int budget, input string nm);
      int n = 0;
      while (!(int'(x) == wx && int'(y) == wy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) tmo(nm);
   endtask

   // Monitor: compare the head expectation on the first clock the beam sits on its pixel.
   always @(negedge clk) begin
      if (!rst && exp_q.size() > 0) begin
         if (int'(x) == exp_q[0].px && int'(y) == exp_q[0].py) begin
            e_mon = exp_q.pop_front();
            chk({e_mon.name, ".in_board"},     int'(in_board),     e_mon.ib);
            chk({e_mon.name, ".number"},       int'(number),       e_mon.num);
            chk({e_mon.name, ".x_offset"},     int'(x_offset),     e_mon.xo);
            chk({e_mon.name, ".y_offset"},     int'(y_offset),     e_mon.yo);
            chk({e_mon.name, ".active_pixel"}, int'(active_pixel), e_mon.act);
         end
      end
   end

   initial begin
      int cnt, lows, first_low, n;
      bit changed;

      rst   = 1'b1;
      board = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (1000) @(negedge clk);
      chk("pre_reset_x_moving", int'(x != 0), 1);

      // Mid-line reset acts immediately
      rst = 1'b1;
      #1;
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      chk("rst_number", int'(number), 0);
      chk("rst_active_pixel", int'(active_pixel), 0);
      chk("rst_video_on", int'(video_on), 0);
      chk("rst_in_board", int'(in_board), 0);
      repeat (3) @(negedge clk);
      chk("rst_hold_x", int'(x), 0);

      set_tile(0, 2);
      set_tile(6, 2048);
      set_tile(15, 8);
      rst = 1'b0;

      // Frame A: snapshot was cleared by reset, so the tile reads empty
      push("A_tile6", 325, 135, 1, 0, 325, 135, 1);

      wait_xy(0, 10, 50000, "wait_line10");
      cnt = 0; lows = 0; first_low = -1;
      do begin
         @(negedge clk);
         cnt++;
         if (!hsync) begin
            lows++;
            if (first_low < 0) first_low = int'(x);
         end
      end while (!(x == 10'd0 && y == 10'd11) && cnt < 4000);
      chk("line_period_clks", cnt, DIV*800);
      chk("hsync_low_clks", lows, DIV*96);
      chk("hsync_start_x", first_low, 656);

      n = 0;
      while (vsync && n < 900000) begin @(negedge clk); n++; end
      if (n >= 900000) tmo("vsync_fall");
      chk("vsync_fall_y", int'(y), 490);
      chk("vsync_fall_x", int'(x), 0);
      cnt = 0;
      while (!vsync && cnt < 900000) begin @(negedge clk); cnt++; end
      chk("vsync_low_clks", cnt, DIV*800*2);
      chk("vsync_rise_y", int'(y), 492);

      n = 0;
      while (!frame_start && n < 900000) begin @(negedge clk); n++; end
      if (n >= 900000) tmo("frame_start_1");
      chk("fs1_x", int'(x), 0);
      chk("fs1_y", int'(y), 0);

      // Frame B: snapshot holds the board captured at the end of frame A
      push("B_tile0", 105, 25, 1, 2, 105, 25, 1);
      push("B_border", 324, 135, 1, 2048, 325, 135, 0);
      push("B_tile6", 325, 135, 1, 2048, 325, 135, 1);
      push("B_right_edge", 540, 135, 0, 0, 0, 0, 0);
      push("B_tile15_frozen", 435, 355, 1, 8, 435, 355, 1);

      @(negedge clk);
      cnt = 1;
      chk("fs_width", int'(frame_start), 0);
      changed = 1'b0;
      while (!frame_start && cnt < 900000) begin
         if (!changed && y == 10'd200) begin
            set_tile(0, 4);
            set_tile(15, 16);
            changed = 1'b1;
            push("C_tile0", 105, 25, 1, 4, 105, 25, 1);
            push("C_tile15", 435, 355, 1, 16, 435, 355, 1);
            push("C_bottom_edge", 435, 460, 0, 0, 0, 0, 0);
         end
         @(negedge clk);
         cnt++;
      end
      chk("frame_period_clks", cnt, DIV*800*525);

      n = 0;
      while (exp_q.size() > 0 && n < 900000) begin @(negedge clk); n++; end
      if (exp_q.size() > 0) tmo("scoreboard_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
